// File: rtl/fact_sched_pkg.sv
// Shared types and constants for the factorial job scheduler.
package fact_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO,
    POLL,
    READ,
    CLR_GO,
    RESP
  } state_e;

  localparam logic [1:0] FACT_A_N    = 2'd0;
  localparam logic [1:0] FACT_A_GO   = 2'd1;
  localparam logic [1:0] FACT_A_DONE = 2'd2;
  localparam logic [1:0] FACT_A_RES  = 2'd3;

  localparam int unsigned N_MAX_DEF = 12;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] ready_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    ready_o[0]   = en_i & valid_i[0] & (~valid_i[1] | last_grant_q);
    ready_o[1]   = en_i & valid_i[1] & (~valid_i[0] | ~last_grant_q);
    last_grant_d = last_grant_q;
    if (ready_o[1]) begin
      last_grant_d = 1'b1;
    end else if (ready_o[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/fact_job_scheduler.sv
// Shares one memory-mapped factorial peripheral between two requesters,
// sequencing write-n / Go / poll Done / read Result / clear Go per job.
module fact_job_scheduler
  import fact_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned N_MAX   = N_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic [3:0]  req_n0,
  output logic        req_ready0,
  input  logic        req_valid1,
  input  logic [3:0]  req_n1,
  output logic        req_ready1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  fact_a,
  output logic        fact_we,
  output logic [3:0]  fact_wd,
  input  logic [31:0] fact_rd
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  logic [3:0]       n_q, n_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [1:0]       fact_a_q, fact_a_d;
  logic             fact_we_q, fact_we_d;
  logic [3:0]       fact_wd_q, fact_wd_d;
  logic             busy_q, busy_d;
  logic             rsp_valid0_q, rsp_valid0_d;
  logic             rsp_valid1_q, rsp_valid1_d;

  logic             idle_c;
  logic [1:0]       grant_c;
  logic [3:0]       n_sel_c;

  assign idle_c  = (state_q == IDLE);
  assign n_sel_c = grant_c[1] ? req_n1 : req_n0;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (idle_c),
    .valid_i ({req_valid1, req_valid0}),
    .ready_o (grant_c)
  );

  // Next state, then registered outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          owner_d = grant_c[1];
          n_d     = n_sel_c;
          data_d  = 32'd0;
          err_d   = (n_sel_c > 4'(N_MAX));
          state_d = (n_sel_c > 4'(N_MAX)) ? RESP : WR_N;
        end
      end
      WR_N:  state_d = WR_GO;
      WR_GO: begin
        cnt_d   = '0;
        state_d = POLL;
      end
      POLL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q >= CNT_W'(SETTLE)) && fact_rd[0]) begin
          state_d = READ;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = CLR_GO;
        end
      end
      READ: begin
        data_d  = fact_rd;
        err_d   = 1'b0;
        state_d = CLR_GO;
      end
      CLR_GO: state_d = RESP;
      RESP: begin
        if (owner_q ? rsp_ready1 : rsp_ready0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fact_a_d  = FACT_A_N;
    fact_we_d = 1'b0;
    fact_wd_d = 4'd0;
    case (state_d)
      WR_N: begin
        fact_a_d  = FACT_A_N;
        fact_we_d = 1'b1;
        fact_wd_d = n_d;
      end
      WR_GO: begin
        fact_a_d  = FACT_A_GO;
        fact_we_d = 1'b1;
        fact_wd_d = 4'd1;
      end
      POLL:   fact_a_d = FACT_A_DONE;
      READ:   fact_a_d = FACT_A_RES;
      CLR_GO: begin
        fact_a_d  = FACT_A_GO;
        fact_we_d = 1'b1;
      end
      default: ;
    endcase

    busy_d       = (state_d != IDLE);
    rsp_valid0_d = (state_d == RESP) && !owner_d;
    rsp_valid1_d = (state_d == RESP) && owner_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_q          <= 4'd0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      data_q       <= 32'd0;
      err_q        <= 1'b0;
      fact_a_q     <= FACT_A_N;
      fact_we_q    <= 1'b0;
      fact_wd_q    <= 4'd0;
      busy_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
      fact_a_q     <= fact_a_d;
      fact_we_q    <= fact_we_d;
      fact_wd_q    <= fact_wd_d;
      busy_q       <= busy_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
    end
  end

  assign req_ready0 = grant_c[0];
  assign req_ready1 = grant_c[1];
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign fact_a     = fact_a_q;
  assign fact_we    = fact_we_q;
  assign fact_wd    = fact_wd_q;

endmodule

// File: tb/tb_fact_job_scheduler.sv
// Directed bench for fact_job_scheduler with a peripheral model and a
// transaction-level expected-trace model checked every cycle.
module tb_fact_job_scheduler;

  localparam int TIMEOUT = 16;
  localparam int SETTLE  = 2;
  localparam int N_MAX   = 12;
  localparam int LAT     = 4;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_STALE  = 1;
  localparam int MODE_STUCK0 = 2;

  logic        clk, rst;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [3:0]  req_n0, req_n1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;
  logic [1:0]  fact_a;
  logic        fact_we;
  logic [3:0]  fact_wd;
  logic [31:0] fact_rd;

  int errors = 0;
  int checks = 0;
  int mode   = MODE_NORMAL;
  int poll_cnt = 0;

  fact_job_scheduler #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .N_MAX(N_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_n0(req_n0), .req_ready0(req_ready0),
    .req_valid1(req_valid1), .req_n1(req_n1), .req_ready1(req_ready1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .fact_a(fact_a), .fact_we(fact_we), .fact_wd(fact_wd), .fact_rd(fact_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fact(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral: Done rises LAT cycles after Go; STALE keeps the old Done.
  logic [3:0]  p_n;
  logic        p_go, p_done;
  logic [31:0] p_res;
  logic [7:0]  p_since;

  always @(posedge clk) begin
    if (fact_we && fact_a == 2'd0) p_n <= fact_wd;
    if (fact_we && fact_a == 2'd1) begin
      p_go <= fact_wd[0];
      if (fact_wd[0]) begin
        p_res   <= fact(int'(p_n));
        p_since <= 8'd0;
        if (mode != MODE_STALE) p_done <= 1'b0;
      end
    end else if (p_go) begin
      p_since <= p_since + 8'd1;
      if (int'(p_since) + 1 >= LAT) p_done <= 1'b1;
    end
  end

  always_comb begin
    case (fact_a)
      2'd0:    fact_rd = {28'd0, p_n};
      2'd1:    fact_rd = {31'd0, p_go};
      2'd2:    fact_rd = {31'd0, (mode == MODE_STUCK0) ? 1'b0 : p_done};
      default: fact_rd = p_res;
    endcase
  end

  initial begin
    p_n = 4'd0; p_go = 1'b0; p_done = 1'b0; p_res = 32'd0; p_since = 8'd0;
  end

  // Requester drivers: present queued jobs, pop on handshake.
  int unsigned job_q0[$];
  int unsigned job_q1[$];

  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = req_valid0 && req_ready0 && rst;
      @(posedge clk); #1;
      if (hs && job_q0.size() > 0) void'(job_q0.pop_front());
      if (job_q0.size() > 0) begin req_valid0 = 1'b1; req_n0 = 4'(job_q0[0]); end
      else req_valid0 = 1'b0;
    end
  end

  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = req_valid1 && req_ready1 && rst;
      @(posedge clk); #1;
      if (hs && job_q1.size() > 0) void'(job_q1.pop_front());
      if (job_q1.size() > 0) begin req_valid1 = 1'b1; req_n1 = 4'(job_q1[0]); end
      else req_valid1 = 1'b0;
    end
  end

  // Model: on each accepted job, the expected bus trace and response.
  typedef struct packed {
    logic [1:0] fa;
    logic       fwe;
    logic [3:0] fwd;
  } bus_t;

  bus_t        exp_q[$];
  bit          m_resp, m_last, m_owner, m_err, m_dchk;
  logic [31:0] m_data;

  task automatic push_bus(input logic [1:0] a, input logic we, input logic [3:0] wd);
    bus_t b;
    b.fa = a; b.fwe = we; b.fwd = wd;
    exp_q.push_back(b);
  endtask

  task automatic accept(input bit owner, input logic [3:0] n);
    int  polls;
    bit  to;
    m_owner = owner;
    m_last  = owner;
    m_resp  = 1'b1;
    if (int'(n) > N_MAX) begin
      m_err = 1'b1; m_data = 32'd0; m_dchk = 1'b1;
    end else begin
      to = (mode == MODE_STUCK0);
      if (to) polls = TIMEOUT;
      else if (mode == MODE_STALE) polls = SETTLE + 1;
      else polls = ((LAT > SETTLE) ? LAT : SETTLE) + 1;
      push_bus(2'd0, 1'b1, n);
      push_bus(2'd1, 1'b1, 4'd1);
      for (int i = 0; i < polls; i++) push_bus(2'd2, 1'b0, 4'd0);
      if (!to) push_bus(2'd3, 1'b0, 4'd0);
      push_bus(2'd1, 1'b1, 4'd0);
      m_err = to; m_data = fact(int'(n)); m_dchk = !to;
    end
  endtask

  initial begin
    bus_t e;
    bit   r0, r1;
    m_resp = 1'b0; m_last = 1'b1; m_owner = 1'b0;
    m_err = 1'b0; m_dchk = 1'b0; m_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        m_resp = 1'b0;
        m_last = 1'b1;
      end else begin
        if (fact_a == 2'd2 && busy) poll_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bus_a", fact_a, e.fa);
          chk("bus_we", fact_we, e.fwe);
          chk("bus_wd", fact_wd, e.fwd);
          chk("job_busy", busy, 1);
          chk("job_rsp_valid0", rsp_valid0, 0);
          chk("job_rsp_valid1", rsp_valid1, 0);
          chk("job_req_ready", {req_ready1, req_ready0}, 0);
        end else if (m_resp) begin
          chk("rsp_valid0", rsp_valid0, !m_owner);
          chk("rsp_valid1", rsp_valid1, m_owner);
          chk("rsp_err", rsp_err, m_err);
          if (m_dchk) chk("rsp_data", rsp_data, m_data);
          chk("rsp_busy", busy, 1);
          chk("rsp_bus", {fact_a, fact_we, fact_wd}, 0);
          chk("rsp_req_ready", {req_ready1, req_ready0}, 0);
          if (m_owner ? rsp_ready1 : rsp_ready0) m_resp = 1'b0;
        end else begin
          r0 = req_valid0 && (!req_valid1 || m_last);
          r1 = req_valid1 && (!req_valid0 || !m_last);
          chk("req_ready0", req_ready0, r0);
          chk("req_ready1", req_ready1, r1);
          chk("idle_busy", busy, 0);
          chk("idle_rsp_valid", {rsp_valid1, rsp_valid0}, 0);
          chk("idle_bus", {fact_a, fact_we, fact_wd}, 0);
          if (r1) accept(1'b1, req_n1);
          else if (r0) accept(1'b0, req_n0);
        end
      end
    end
  end

  task automatic wait_rsp(input bit owner, input logic [31:0] data, input bit err, input bit dchk);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (owner ? rsp_valid1 : rsp_valid0) got = 1'b1;
    end
    if (!got) chk("rsp_wait_timeout", 0, 1);
    else begin
      chk("lit_rsp_err", rsp_err, err);
      if (dchk) chk("lit_rsp_data", rsp_data, data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fact_a"}, fact_a, 0);
    chk({tag, "_fact_we"}, fact_we, 0);
    chk({tag, "_fact_wd"}, fact_wd, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, {rsp_valid1, rsp_valid0}, 0);
    chk({tag, "_req_ready"}, {req_ready1, req_ready0}, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_n0 = 4'd0; req_n1 = 4'd0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    job_q0.push_back(5);
    wait_rsp(1'b0, 32'd120, 1'b0, 1'b1);

    job_q1.push_back(13);
    wait_rsp(1'b1, 32'd0, 1'b1, 1'b1);

    job_q0.push_back(3); job_q0.push_back(2); job_q1.push_back(4);
    wait_rsp(1'b0, 32'd6, 1'b0, 1'b1);
    wait_rsp(1'b1, 32'd24, 1'b0, 1'b1);
    wait_rsp(1'b0, 32'd2, 1'b0, 1'b1);

    job_q1.push_back(12);
    wait_rsp(1'b1, 32'd479001600, 1'b0, 1'b1);
    job_q0.push_back(0);
    wait_rsp(1'b0, 32'd1, 1'b0, 1'b1);

    @(posedge clk); #1;
    mode = MODE_STALE; poll_cnt = 0;
    job_q0.push_back(6);
    wait_rsp(1'b0, 32'd720, 1'b0, 1'b1);
    chk("stale_polls", poll_cnt, 3);

    @(posedge clk); #1;
    mode = MODE_STUCK0; poll_cnt = 0;
    job_q1.push_back(7);
    wait_rsp(1'b1, 32'd0, 1'b1, 1'b0);
    chk("timeout_polls", poll_cnt, 16);

    @(posedge clk); #1;
    mode = MODE_NORMAL;
    rsp_ready0 = 1'b0;
    job_q0.push_back(4);
    wait_rsp(1'b0, 32'd24, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid0", rsp_valid0, 1);
      chk("hold_rsp_data", rsp_data, 32'd24);
      chk("hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;

    job_q0.push_back(8);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (fact_a == 2'd2) seen = 1'b1;
    end
    if (!seen) chk("poll_wait_timeout", 0, 1);
    @(posedge clk); #2;
    job_q0.delete(); job_q1.delete();
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", busy, 0);

    job_q1.push_back(9);
    wait_rsp(1'b1, 32'd362880, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
